// File: rtl/alu.sv
// rtl/alu.sv - RV32I execute-stage ALU with combinational result and registered EX/MEM copy
// Optional zero flag outputs (o_zero, o_zero_q) are present when ALU_FLAGS_EN is defined.
module alu #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic [OP_W-1:0]   i_alu_op,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_alu_data,
  output logic [DATA_W-1:0] o_alu_data_q,
`ifdef ALU_FLAGS_EN
  output logic              o_zero,
  output logic              o_zero_q,
`endif
  output logic              o_valid_q
);

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;

  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  // Only the low five bits of operand B select the shift distance.
  assign shamt       = i_op_b[4:0];
  assign lt_signed   = $signed(i_op_a) < $signed(i_op_b);
  assign lt_unsigned = i_op_a < i_op_b;

  always_comb begin
    o_alu_data = '0;
    case (i_alu_op)
      OP_ADD:  o_alu_data = i_op_a + i_op_b;
      OP_SUB:  o_alu_data = i_op_a - i_op_b;
      OP_SLT:  o_alu_data = {{(DATA_W-1){1'b0}}, lt_signed};
      OP_SLTU: o_alu_data = {{(DATA_W-1){1'b0}}, lt_unsigned};
      OP_XOR:  o_alu_data = i_op_a ^ i_op_b;
      OP_OR:   o_alu_data = i_op_a | i_op_b;
      OP_AND:  o_alu_data = i_op_a & i_op_b;
      OP_SLL:  o_alu_data = i_op_a << shamt;
      OP_SRL:  o_alu_data = i_op_a >> shamt;
      OP_SRA:  o_alu_data = $unsigned($signed(i_op_a) >>> shamt);
      default: o_alu_data = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  assign o_zero = (o_alu_data == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_zero_q <= 1'b0;
    end else begin
      o_zero_q <= o_zero;
    end
  end
`endif

  // Data is captured every cycle; downstream qualifies it with o_valid_q.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_alu_data_q <= '0;
      o_valid_q    <= 1'b0;
    end else begin
      o_alu_data_q <= o_alu_data;
      o_valid_q    <= i_valid;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu (zero flags checked when ALU_FLAGS_EN is defined)
module tb_alu;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [3:0]  i_alu_op;
  logic        i_valid;
  logic [31:0] o_alu_data;
  logic [31:0] o_alu_data_q;
  logic        o_valid_q;
`ifdef ALU_FLAGS_EN
  logic        o_zero;
  logic        o_zero_q;
`endif

  int checks = 0;
  int errors = 0;

  alu dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_alu_op    (i_alu_op),
    .i_valid     (i_valid),
    .o_alu_data  (o_alu_data),
    .o_alu_data_q(o_alu_data_q),
`ifdef ALU_FLAGS_EN
    .o_zero      (o_zero),
    .o_zero_q    (o_zero_q),
`endif
    .o_valid_q   (o_valid_q)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_alu_op = op;
    i_op_a   = a;
    i_op_b   = b;
    #1;
  endtask

  initial begin
    logic [31:0] and_a;
    logic [31:0] and_b;
    i_rst    = 1'b1;
    i_op_a   = 32'd0;
    i_op_b   = 32'd0;
    i_alu_op = 4'b0000;
    i_valid  = 1'b1;

    // reset held for two edges
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    chk("rst_data_q", o_alu_data_q, 32'd0);
    chk("rst_valid_q", {31'd0, o_valid_q}, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_zero_q", {31'd0, o_zero_q}, 32'd0);
`endif

    drive(4'b0000, 32'd3232453, 32'd4995);
    chk("add_pos", o_alu_data, 32'd3237448);
    drive(4'b0000, -32'sd3232453, -32'sd4995);
    chk("add_neg", o_alu_data, -32'sd3237448);
    drive(4'b0000, 32'hFFFF_FFFF, 32'd1);
    chk("add_wrap", o_alu_data, 32'd0);
`ifdef ALU_FLAGS_EN
    chk("zero_set", {31'd0, o_zero}, 32'd1);
`endif
    drive(4'b0001, 32'd43750349, -32'sd392837334);
    chk("sub", o_alu_data, 32'd436587683);
`ifdef ALU_FLAGS_EN
    chk("zero_clr", {31'd0, o_zero}, 32'd0);
`endif
    drive(4'b0001, 32'd0, 32'd1);
    chk("sub_wrap", o_alu_data, 32'hFFFF_FFFF);

    drive(4'b0100, 32'd12398, 32'd45);
    chk("xor", o_alu_data, 32'd12355);
    drive(4'b0101, 32'd12398, 32'd45);
    chk("or", o_alu_data, 32'd12399);
    and_a = 32'd1800000032;
    and_b = 32'd1283744400;
    drive(4'b0110, and_a, and_b);
    chk("and", o_alu_data, and_a & and_b);

    drive(4'b0111, 32'd49, 32'd5);
    chk("sll", o_alu_data, 32'd1568);
    drive(4'b1000, 32'd12033, 32'd5);
    chk("srl", o_alu_data, 32'd376);
    drive(4'b1001, -32'sd445060133, 32'd15);
    chk("sra", o_alu_data, -32'sd13583);
    drive(4'b0111, 32'd1, 32'h21);
    chk("sll_b_hi_ignored", o_alu_data, 32'd2);
    drive(4'b1000, 32'h8000_0000, 32'd31);
    chk("srl_31", o_alu_data, 32'd1);
    drive(4'b1001, 32'h8000_0000, 32'd31);
    chk("sra_31", o_alu_data, 32'hFFFF_FFFF);
    drive(4'b1001, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    chk("sra_amt0", o_alu_data, 32'hDEAD_BEEF);

    drive(4'b0011, -32'sd25002, -32'sd4000);
    chk("sltu_negneg", o_alu_data, 32'd1);
    drive(4'b0011, 32'd75830, -32'sd2834000);
    chk("sltu_posneg", o_alu_data, 32'd1);
    drive(4'b0011, 32'd25002, 32'd4000);
    chk("sltu_false", o_alu_data, 32'd0);
    drive(4'b0010, -32'sd18930002, 32'd102847);
    chk("slt_negpos", o_alu_data, 32'd1);
    drive(4'b0010, 32'd75830, -32'sd2834000);
    chk("slt_posneg", o_alu_data, 32'd0);
    drive(4'b0010, 32'd125002, 32'd3404000);
    chk("slt_pospos", o_alu_data, 32'd1);
    drive(4'b0010, 32'd7, 32'd7);
    chk("slt_equal", o_alu_data, 32'd0);

    drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("op_1111", o_alu_data, 32'd0);
    drive(4'b1010, 32'd5, 32'd3);
    chk("op_1010", o_alu_data, 32'd0);

    // register path: release reset, then one valid ADD
    drive(4'b0000, 32'd1, 32'd2);
    i_rst   = 1'b0;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    chk("reg_add_data", o_alu_data_q, 32'd3);
    chk("reg_add_valid", {31'd0, o_valid_q}, 32'd1);
`ifdef ALU_FLAGS_EN
    chk("reg_zero_q", {31'd0, o_zero_q}, 32'd0);
`endif

    drive(4'b0001, 32'd10, 32'd4);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk("reg_invalid_data", o_alu_data_q, 32'd6);
    chk("reg_invalid_valid", {31'd0, o_valid_q}, 32'd0);

    drive(4'b0000, 32'd100, 32'd23);
    i_valid = 1'b1;
    i_rst   = 1'b1;
    chk("comb_during_rst", o_alu_data, 32'd123);
    @(posedge i_clk);
    #1;
    chk("midrst_data_q", o_alu_data_q, 32'd0);
    chk("midrst_valid_q", {31'd0, o_valid_q}, 32'd0);

    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("post_rst_data_q", o_alu_data_q, 32'd123);
    chk("post_rst_valid_q", {31'd0, o_valid_q}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RV32I core execute stage.
- Computes ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL and SRA on two 32-bit operands, selected by a 4-bit opcode from the decoder.
- The result is available combinationally for forwarding and branch/address use.
- A registered copy of the result feeds the EX/MEM boundary.

Parameters:
- DATA_W, 32, operand and result width. Only 32 is supported.
- OP_W, 4, opcode width.

Ports:
- i_clk  input  1  single clock; all registers update on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_op_a  input  32  operand A (rs1 / PC).
- i_op_b  input  32  operand B (rs2 / immediate); bits [4:0] are the shift amount.
- i_alu_op  input  4  operation select.
- i_valid  input  1  the current inputs form a real operation.
- o_alu_data  output  32  combinational result.
- o_alu_data_q  output  32  registered result, 1-cycle latency.
- o_valid_q  output  1  registered i_valid, aligned with o_alu_data_q.

Behaviour:
- Opcodes:
  - 0000 ADD: a+b.
  - 0001 SUB: a-b.
  - 0010 SLT: signed a<b.
  - 0011 SLTU: unsigned a<b.
  - 0100 XOR.
  - 0101 OR.
  - 0110 AND.
  - 0111 SLL: a<<b[4:0].
  - 1000 SRL: logical a>>b[4:0].
  - 1001 SRA: arithmetic, sign-filled a>>>b[4:0].
- Opcodes 1010-1111: o_alu_data = 0.
- ADD/SUB wrap modulo 2^32; there is no overflow flag.
- SLT/SLTU: bit 0 = comparison result, bits [31:1] = 0.
- Shifts use only b[4:0]; b[31:5] are ignored. A shift amount of 0 returns a unchanged.
- o_alu_data is purely combinational:
  - no dependence on i_clk, i_rst or i_valid;
  - settles within the same cycle, well inside 1 ns in simulation;
  - no latches; every output bit is assigned on every path.
- On each rising edge of i_clk:
  - if i_rst = 1: o_alu_data_q = 0 and o_valid_q = 0;
  - else: o_alu_data_q = o_alu_data and o_valid_q = i_valid.
- o_alu_data_q captures regardless of i_valid. Consumers qualify it with o_valid_q.
- Reset asserted mid-stream clears the registered outputs on the next edge. The combinational output keeps tracking the inputs during reset.
- No internal state beyond the two output registers; there is no stall or handshake.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, two extra outputs are present:
  - o_zero (1 bit): 1 when o_alu_data == 0, combinational; used by BEQ/BNE.
  - o_zero_q: registered copy of o_zero; reset value 0.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- ADD: a=3232453, b=4995 -> 3237448. ADD: a=-3232453, b=-4995 -> -3237448.
- SUB: a=43750349, b=-392837334 -> 436587683.
- Logic ops on a=12398, b=45:
  - XOR -> 12355.
  - OR -> 12399.
  - AND with a=1800000032, b=1283744400 -> bitwise AND of the operands.
- Shifts:
  - SLL a=49, b=5 -> 1568.
  - SRL a=12033, b=5 -> 376.
  - SRA a=-445060133, b=15 -> -13583.
  - SLL a=1, b=0x21 -> 2 (only b[4:0] is used).
- Compares:
  - SLTU a=-25002, b=-4000 -> 1.
  - SLTU a=75830, b=-2834000 -> 1.
  - SLTU a=25002, b=4000 -> 0.
  - SLT a=-18930002, b=102847 -> 1.
  - SLT a=75830, b=-2834000 -> 0.
  - SLT a=125002, b=3404000 -> 1.
- Register path:
  - hold i_rst=1 for 2 cycles -> o_alu_data_q=0, o_valid_q=0;
  - release, apply ADD 1+2 with i_valid=1 -> o_alu_data_q=3 and o_valid_q=1 after one edge;
  - assert i_rst mid-stream -> registered outputs are 0 on the next edge;
  - opcode 1111 -> o_alu_data=0.
